// File: rtl/serial_magnitude_comparator_if.sv
// Start/done operand and result bundle for the serial magnitude comparator.
// The comparator owns the slave side; the requesting logic owns the master side.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             g_in;
  logic             e_in;
  logic             l_in;
  logic             busy;
  logic             done;
  logic             g_o;
  logic             e_o;
  logic             l_o;

  modport master (
    output start, signed_mode, a, b, g_in, e_in, l_in,
    input  busy, done, g_o, e_o, l_o
  );

  modport slave (
    input  start, signed_mode, a, b, g_in, e_in, l_in,
    output busy, done, g_o, e_o, l_o
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock with early exit.
// The cascade inputs decide the result only when every slice compares equal.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int unsigned S  = WIDTH / DIGIT;
  localparam int unsigned IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nx;
  logic [IW-1:0]    r_idx, w_idx_nx;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_signed;
  logic [2:0]       r_cas;
  logic             r_busy, r_done, r_g, r_e, r_l;
  logic             w_busy_nx, w_done_nx, w_g_nx, w_e_nx, w_l_nx;
  logic             w_load_c;
  logic [31:0]      w_shamt;
  logic [WIDTH-1:0] w_a_sh, w_b_sh;
  logic [DIGIT-1:0] w_a_dig, w_b_dig;
  logic             w_gt, w_lt;

  // Current slice; in signed mode the top slice has its sign bit flipped so that
  // an unsigned compare orders two's-complement values correctly.
  always_comb begin
    w_shamt = 32'(r_idx) * 32'(DIGIT);
    w_a_sh  = r_a >> w_shamt;
    w_b_sh  = r_b >> w_shamt;
    w_a_dig = w_a_sh[DIGIT-1:0];
    w_b_dig = w_b_sh[DIGIT-1:0];
    if (r_signed && (r_idx == IW'(S - 1))) begin
      w_a_dig[DIGIT-1] = ~w_a_dig[DIGIT-1];
      w_b_dig[DIGIT-1] = ~w_b_dig[DIGIT-1];
    end
    w_gt = (w_a_dig > w_b_dig);
    w_lt = (w_a_dig < w_b_dig);
  end

  // Next state and next registered outputs; results only move on entry to DONE.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;
    w_g_nx     = r_g;
    w_e_nx     = r_e;
    w_l_nx     = r_l;
    w_load_c   = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        w_state_nx = IDLE;
        if (bus.start) begin
          w_load_c   = 1'b1;
          w_idx_nx   = IW'(S - 1);
          w_state_nx = RUN;
          w_busy_nx  = 1'b1;
        end
      end
      RUN: begin
        w_busy_nx = 1'b1;
        if (w_gt || w_lt) begin
          w_g_nx     = w_gt;
          w_e_nx     = 1'b0;
          w_l_nx     = w_lt;
          w_state_nx = DONE;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else if (r_idx == IW'(0)) begin
          w_g_nx     = r_cas[2];
          w_e_nx     = r_cas[1];
          w_l_nx     = r_cas[0];
          w_state_nx = DONE;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else begin
          w_idx_nx = r_idx - IW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_g     <= 1'b0;
      r_e     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_g     <= w_g_nx;
      r_e     <= w_e_nx;
      r_l     <= w_l_nx;
    end
  end

  // Operand capture; only the accepting edge updates these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_cas    <= '0;
    end else if (w_load_c) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_signed <= bus.signed_mode;
      r_cas    <= {bus.g_in, bus.e_in, bus.l_in};
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.g_o  = r_g;
  assign bus.e_o  = r_e;
  assign bus.l_o  = r_l;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized self-checking bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2).
// Expected results and latencies come from a plain-arithmetic model of the compare.
module tb_serial_magnitude_comparator;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned S     = WIDTH / DIGIT;
  localparam int          LIMIT = 20;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [2:0] prev_res;

  serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result {g,e,l}: plain integer ordering, cascade only when operands are equal.
  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sgn, input logic [2:0] casc);
    if (a == b) return casc;
    if (sgn) return ($signed(a) > $signed(b)) ? 3'b100 : 3'b001;
    return (a > b) ? 3'b100 : 3'b001;
  endfunction

  // Number of RUN cycles: S minus the index of the top differing slice, capped at S.
  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int da, db;
    for (int k = S - 1; k >= 0; k--) begin
      da = (int'(a) >> (k * DIGIT)) % (1 << DIGIT);
      db = (int'(b) >> (k * DIGIT)) % (1 << DIGIT);
      if (da != db) return S - k;
    end
    return S;
  endfunction

  function automatic logic [2:0] obs();
    return {bus.g_o, bus.e_o, bus.l_o};
  endfunction

  // Presents an operation for exactly one sampling edge, then scrambles the operands.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sgn, input logic [2:0] casc);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.signed_mode = sgn;
    {bus.g_in, bus.e_in, bus.l_in} = casc;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
    bus.signed_mode = ~sgn;
    {bus.g_in, bus.e_in, bus.l_in} = ~casc;
  endtask

  // Counts edges until done; flags busy low or result movement before done.
  task automatic wait_done(input logic [2:0] held, output int cycles, output bit run_ok);
    cycles = 0;
    run_ok = 1'b1;
    while (cycles < LIMIT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1 || obs() !== held) run_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int pulses;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    bus.g_in = 1'b0; bus.e_in = 1'b0; bus.l_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, obs()} !== 5'b0) begin
      n_err++; $display("FAIL reset_values got=%b want=00000", {bus.busy, bus.done, obs()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL idle_quiet got=%0d active cycles want=0", pulses);
    end
    prev_res = 3'b000;
  endtask

  // One directed compare with full result/latency/hold checking.
  task automatic test_directed(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic sgn,
                               input logic [2:0] casc, input int want_lat,
                               input logic [2:0] want_res);
    int cyc; bit ok;
    start_op(a, b, sgn, casc);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL %s_busy got=%b want=1", name, bus.busy);
    end
    wait_done(prev_res, cyc, ok);
    n_cmp++;
    if (cyc !== want_lat) begin
      n_err++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, want_lat);
    end
    n_cmp++;
    if (obs() !== want_res || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL %s_result got=%b busy=%b want=%b busy=0", name, obs(), bus.busy, want_res);
    end
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++; $display("FAIL %s_run got=bad busy/held result want=ok", name);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || obs() !== want_res) begin
      n_err++; $display("FAIL %s_pulse got done=%b res=%b want done=0 res=%b", name, bus.done, obs(), want_res);
    end
    prev_res = want_res;
  endtask

  task automatic test_busy_start_and_back_to_back();
    int cyc, pulses; logic [2:0] want;
    start_op(8'h12, 8'h13, 1'b0, 3'b010);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; pulses = 0;
    while (cyc < LIMIT && bus.done !== 1'b1) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc !== model_lat(8'h12, 8'h13) || obs() !== 3'b001) begin
      n_err++; $display("FAIL busy_start got lat=%0d res=%b want lat=4 res=001", cyc, obs());
    end
    // Still in the DONE cycle: request the next compare immediately.
    bus.a = 8'h00; bus.b = 8'h00; bus.signed_mode = 1'b0;
    {bus.g_in, bus.e_in, bus.l_in} = 3'b010;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
    end
    cyc = 0;
    while (cyc < LIMIT) begin
      @(posedge clk); #1; cyc++;
      if (bus.done === 1'b1) pulses++;
      if (bus.done === 1'b1) break;
    end
    want = 3'b010;
    n_cmp++;
    if (cyc !== 4 || obs() !== want || pulses !== 1) begin
      n_err++; $display("FAIL b2b_result got lat=%0d res=%b want lat=4 res=%b", cyc, obs(), want);
    end
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL no_queued_start got=%0d active cycles want=0", pulses);
    end
    prev_res = want;
  endtask

  task automatic test_random(input int n);
    logic [WIDTH-1:0] a, b; logic sgn; logic [2:0] casc, want;
    int cyc, lat, bad; bit ok;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {a[WIDTH-1:DIGIT], b[DIGIT-1:0]};
        2: b = {a[WIDTH-1:WIDTH-DIGIT], b[WIDTH-DIGIT-1:0]};
        default: ;
      endcase
      sgn  = 1'($urandom);
      casc = 3'($urandom);
      want = model_res(a, b, sgn, casc);
      lat  = model_lat(a, b);
      start_op(a, b, sgn, casc);
      wait_done(prev_res, cyc, ok);
      n_cmp++;
      if (cyc !== lat || obs() !== want || ok !== 1'b1) begin
        n_err++;
        $display("FAIL random_%0d a=%h b=%h s=%b c=%b got lat=%0d res=%b run=%b want lat=%0d res=%b run=1",
                 i, a, b, sgn, casc, cyc, obs(), ok, lat, want);
      end
      prev_res = want;
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    start_op(8'h01, 8'h02, 1'b0, 3'b010);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, obs()} !== 5'b0) begin
      n_err++; $display("FAIL reset_mid got=%b want=00000", {bus.busy, bus.done, obs()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL reset_mid_quiet got=%0d active cycles want=0", pulses);
    end
    prev_res = 3'b000;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev_res = 3'b000;
    test_reset();
    test_directed("early_exit",   8'hC0, 8'h40, 1'b0, 3'b010, 1, 3'b100);
    test_directed("eq_casc_less", 8'h5A, 8'h5A, 1'b0, 3'b001, 4, 3'b001);
    test_directed("eq_casc_eq",   8'h5A, 8'h5A, 1'b0, 3'b010, 4, 3'b010);
    test_directed("eq_casc_bad",  8'h33, 8'h33, 1'b1, 3'b101, 4, 3'b101);
    test_directed("signed_neg",   8'hFF, 8'h01, 1'b1, 3'b010, 1, 3'b001);
    test_directed("unsigned_ff",  8'hFF, 8'h01, 1'b0, 3'b010, 1, 3'b100);
    test_directed("signed_low",   8'h81, 8'h80, 1'b1, 3'b010, 4, 3'b100);
    test_busy_start_and_back_to_back();
    test_random(60);
    test_reset_mid();
    test_directed("after_reset",  8'h01, 8'h02, 1'b0, 3'b010, 4, 3'b001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
